// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared constants and stage-tag type for the 5-stage pipeline
// hazard logic. The operand-mux select encoding here is shared with the datapath.
package mips_pipe_pkg;

    localparam int PIPE_REG_W = 5;

    // Operand-mux select encoding
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_WB    = 2'b11;

    localparam logic [PIPE_REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [PIPE_REG_W-1:0] dest;
        logic                  regwrite;
        logic                  memread;
    } stage_tag_t;

    localparam int TAG_W = $bits(stage_tag_t);

    // A slot can supply a source only if it really writes a nonzero register
    // that the consumer actually reads.
    function automatic logic tag_hit(input stage_tag_t tag,
                                     input logic [PIPE_REG_W-1:0] src,
                                     input logic uses);
        return tag.valid && tag.regwrite && (tag.dest == src) &&
               (src != REG_ZERO) && uses;
    endfunction

endpackage

// File: rtl/fwd_compare.sv
// fwd_compare: priority match of one source register against the EX/MEM/WB
// shadow tags, producing the operand-mux select. Optional macro
// FWD_WB_BYPASS_EN lets the WB slot produce FWD_WB.
module fwd_compare
    import mips_pipe_pkg::*;
(
    input  logic [PIPE_REG_W-1:0] src_i,
    input  logic                  uses_i,
    input  logic [TAG_W-1:0]      ex_tag_i,
    input  logic [TAG_W-1:0]      mem_tag_i,
    input  logic [TAG_W-1:0]      wb_tag_i,
    output logic [1:0]            sel_o
);

    stage_tag_t ex_tag, mem_tag, wb_tag;
    logic       ex_hit, mem_hit, wb_hit;

    assign ex_tag  = stage_tag_t'(ex_tag_i);
    assign mem_tag = stage_tag_t'(mem_tag_i);
    assign wb_tag  = stage_tag_t'(wb_tag_i);

    assign ex_hit  = tag_hit(ex_tag,  src_i, uses_i);
    assign mem_hit = tag_hit(mem_tag, src_i, uses_i);
    assign wb_hit  = tag_hit(wb_tag,  src_i, uses_i);

    // Nearest producer wins: EX over MEM over WB.
    always_comb begin
        sel_o = FWD_RF;
        if (ex_hit) begin
            sel_o = FWD_EXMEM;
        end else if (mem_hit) begin
            sel_o = FWD_MEMWB;
        end
`ifdef FWD_WB_BYPASS_EN
        else if (wb_hit) begin
            sel_o = FWD_WB;
        end
`endif
    end

`ifndef FWD_WB_BYPASS_EN
    // Write-first register file: the WB slot is tracked but never selected.
    logic unused_wb_hit;
    assign unused_wb_hit = wb_hit;
`endif

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding-select and load-use stall controller for the
// 5-stage MIPS pipeline. Keeps a private EX/MEM/WB tag pipeline so the datapath
// need not export hazard state. Optional macro FWD_WB_BYPASS_EN enables
// the WB-slot bypass (select 11) for a read-before-write register file.
// REG_W is expected to equal mips_pipe_pkg::PIPE_REG_W.
module fwd_hazard_unit
    import mips_pipe_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_regwrite,
    input  logic             id_memread,
    output logic [1:0]       fwdA_sel,
    output logic [1:0]       fwdB_sel,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_tag_t ex_q, mem_q, wb_q;
    stage_tag_t ex_d;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [1:0] cmp_a, cmp_b;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [PIPE_REG_W-1:0] rs_w, rt_w, dest_w;
    logic                  stall_w, enter_ex;

    assign rs_w   = PIPE_REG_W'(id_rs);
    assign rt_w   = PIPE_REG_W'(id_rt);
    assign dest_w = PIPE_REG_W'(id_dest);

    fwd_compare u_cmp_a (
        .src_i     (rs_w),
        .uses_i    (id_uses_rs),
        .ex_tag_i  (ex_q),
        .mem_tag_i (mem_q),
        .wb_tag_i  (wb_q),
        .sel_o     (cmp_a)
    );

    fwd_compare u_cmp_b (
        .src_i     (rt_w),
        .uses_i    (id_uses_rt),
        .ex_tag_i  (ex_q),
        .mem_tag_i (mem_q),
        .wb_tag_i  (wb_q),
        .sel_o     (cmp_b)
    );

    // Load-use detection against the load currently in EX; a flush overrides it.
    always_comb begin
        stall_w = id_valid && !flush && ex_q.valid && ex_q.memread &&
                  (ex_q.dest != REG_ZERO) &&
                  ((id_uses_rs && (rs_w == ex_q.dest)) ||
                   (id_uses_rt && (rt_w == ex_q.dest)));
    end

    // Next EX tag and selects: a bubble enters EX with both selects at RF.
    always_comb begin
        enter_ex = id_valid && !stall_w && !flush;
        ex_d     = '0;
        fwd_a_d  = FWD_RF;
        fwd_b_d  = FWD_RF;
        if (enter_ex) begin
            ex_d.valid    = 1'b1;
            ex_d.dest     = dest_w;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
            fwd_a_d       = cmp_a;
            fwd_b_d       = cmp_b;
        end
    end

    // Saturating stall counter: holds at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_w && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Advance the tag pipeline and registered selects unless frozen by hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
        end else if (!hold) begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwdA_sel  = fwd_a_q;
    assign fwdB_sel  = fwd_b_q;
    assign stall     = stall_w;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit (CNT_W=4 so saturation is reachable).
module tb_fwd_hazard_unit;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;
`ifdef FWD_WB_BYPASS_EN
    localparam logic [1:0] WB_EXP = 2'b11;
`else
    localparam logic [1:0] WB_EXP = 2'b00;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             hold = 1'b0;
    logic             flush = 1'b0;
    logic             id_valid = 1'b0;
    logic [REG_W-1:0] id_rs = '0;
    logic [REG_W-1:0] id_rt = '0;
    logic             id_uses_rs = 1'b0;
    logic             id_uses_rt = 1'b0;
    logic [REG_W-1:0] id_dest = '0;
    logic             id_regwrite = 1'b0;
    logic             id_memread = 1'b0;
    logic [1:0]       fwdA_sel, fwdB_sel;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    fwd_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .id_dest    (id_dest),
        .id_regwrite(id_regwrite),
        .id_memread (id_memread),
        .fwdA_sel   (fwdA_sel),
        .fwdB_sel   (fwdB_sel),
        .stall      (stall),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] dest;
        logic       rw, mr, fl, hd;
        logic       e_stall;
        logic [1:0] e_a, e_b;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vecs [24];
    int   passed = 0;
    int   total  = 0;

    function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic [4:0] dest,
                                input logic rw, input logic mr, input logic fl, input logic hd,
                                input logic es, input logic [1:0] ea, input logic [1:0] eb,
                                input logic [3:0] ec);
        vec_t r;
        r.valid = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.dest = dest;
        r.rw = rw; r.mr = mr; r.fl = fl; r.hd = hd;
        r.e_stall = es; r.e_a = ea; r.e_b = eb; r.e_cnt = ec;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] dest,
                         input logic rw, input logic mr, input logic fl, input logic hd);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_dest = dest; id_regwrite = rw; id_memread = mr; flush = fl; hold = hd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rows: valid rs rt urs urt dest rw mr flush hold | stall selA selB cnt
        vecs[0]  = mk(1, 1, 2, 1,1, 3, 1,0,0,0, 0, 2'b00, 2'b00, 0);  // add $3,$1,$2
        vecs[1]  = mk(1, 3, 5, 1,1, 4, 1,0,0,0, 0, 2'b01, 2'b00, 0);  // sub $4,$3,$5
        vecs[2]  = mk(1, 7, 3, 1,1, 6, 1,0,0,0, 0, 2'b00, 2'b10, 0);  // or  $6,$7,$3
        vecs[3]  = mk(1, 3,10, 1,1, 9, 1,0,0,0, 0, WB_EXP, 2'b00, 0); // and $9,$3,$10
        vecs[4]  = mk(1, 1, 0, 1,0, 2, 1,1,0,0, 0, 2'b00, 2'b00, 0);  // lw  $2
        vecs[5]  = mk(1, 2, 2, 1,1, 8, 1,0,0,0, 1, 2'b00, 2'b00, 1);  // add $8,$2,$2 stalls
        vecs[6]  = mk(1, 2, 2, 1,1, 8, 1,0,0,0, 0, 2'b10, 2'b10, 1);  // reissue
        vecs[7]  = mk(1, 1, 1, 1,1, 0, 1,0,0,0, 0, 2'b00, 2'b00, 1);  // add $0
        vecs[8]  = mk(1, 0, 0, 1,1,11, 1,0,0,0, 0, 2'b00, 2'b00, 1);  // add $11,$0,$0
        vecs[9]  = mk(1, 1, 0, 1,0, 0, 1,1,0,0, 0, 2'b00, 2'b00, 1);  // lw  $0
        vecs[10] = mk(1, 0,11, 1,1,12, 1,0,0,0, 0, 2'b00, 2'b10, 1);  // add $12,$0,$11
        vecs[11] = mk(1, 1, 1, 1,1, 3, 1,0,0,0, 0, 2'b00, 2'b00, 1);  // add $3,$1,$1
        vecs[12] = mk(1, 3, 1, 1,1, 3, 1,0,0,0, 0, 2'b01, 2'b00, 1);  // add $3,$3,$1
        vecs[13] = mk(1, 3, 3, 1,1,13, 1,0,0,0, 0, 2'b01, 2'b01, 1);  // double hit
        vecs[14] = mk(1, 1, 0, 1,0, 5, 1,1,0,0, 0, 2'b00, 2'b00, 1);  // lw  $5
        vecs[15] = mk(1, 5, 1, 1,1,14, 1,0,1,0, 0, 2'b00, 2'b00, 1);  // flush beats stall
        vecs[16] = mk(1, 5,13, 1,1,15, 1,0,0,0, 0, 2'b10, WB_EXP, 1); // add $15,$5,$13
        vecs[17] = mk(1,15, 0, 1,0, 6, 1,1,0,0, 0, 2'b01, 2'b00, 1);  // lw  $6,0($15)
        vecs[18] = mk(1, 6, 0, 1,1,16, 1,0,0,1, 1, 2'b01, 2'b00, 1);  // hold
        vecs[19] = mk(1, 6, 0, 1,1,16, 1,0,0,1, 1, 2'b01, 2'b00, 1);  // hold
        vecs[20] = mk(1, 6, 0, 1,1,16, 1,0,0,1, 1, 2'b01, 2'b00, 1);  // hold
        vecs[21] = mk(1, 6, 0, 1,1,16, 1,0,0,0, 1, 2'b00, 2'b00, 2);  // stall counted
        vecs[22] = mk(1, 6, 0, 1,1,16, 1,0,0,0, 0, 2'b10, 2'b00, 2);  // resume
        vecs[23] = mk(0,16,16, 1,1,17, 1,0,0,0, 0, 2'b00, 2'b00, 2);  // empty ID

        // reset state
        #2;
        chk("reset selA", {6'd0, fwdA_sel}, 8'd0);
        chk("reset selB", {6'd0, fwdB_sel}, 8'd0);
        chk("reset stall", {7'd0, stall}, 8'd0);
        chk("reset cnt", {4'd0, stall_cnt}, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt,
                  vecs[i].dest, vecs[i].rw, vecs[i].mr, vecs[i].fl, vecs[i].hd);
            @(negedge clk);
            chk($sformatf("row%0d stall", i), {7'd0, stall}, {7'd0, vecs[i].e_stall});
            step();
            chk($sformatf("row%0d selA", i), {6'd0, fwdA_sel}, {6'd0, vecs[i].e_a});
            chk($sformatf("row%0d selB", i), {6'd0, fwdB_sel}, {6'd0, vecs[i].e_b});
            chk($sformatf("row%0d cnt", i), {4'd0, stall_cnt}, {4'd0, vecs[i].e_cnt});
        end

        // Reset while a load-use stall is pending and selects are nonzero.
        drive(1, 1, 1, 1,1, 3, 1,0,0,0);              // add $3
        step();
        drive(1, 3, 0, 1,0, 2, 1,1,0,0);              // lw $2,0($3)
        step();
        chk("prerst selA", {6'd0, fwdA_sel}, 8'd1);
        drive(1, 2, 2, 1,1, 8, 1,0,0,0);              // add $8,$2,$2
        @(negedge clk);
        chk("prerst stall", {7'd0, stall}, 8'd1);
        #1 reset = 1'b0;
        #1;
        chk("rst stall", {7'd0, stall}, 8'd0);
        chk("rst selA", {6'd0, fwdA_sel}, 8'd0);
        chk("rst selB", {6'd0, fwdB_sel}, 8'd0);
        chk("rst cnt", {4'd0, stall_cnt}, 8'd0);
        #1 reset = 1'b1;
        #1;
        chk("postrst stall", {7'd0, stall}, 8'd0);
        step();
        chk("postrst selA", {6'd0, fwdA_sel}, 8'd0);
        chk("postrst cnt", {4'd0, stall_cnt}, 8'd0);
        drive(1, 8, 0, 1,0, 9, 1,0,0,0);              // add $9,$8,$0
        step();
        chk("resume selA", {6'd0, fwdA_sel}, 8'd1);

        // Saturation: 20 load-use pairs, counter must stop at 15.
        for (int k = 1; k <= 20; k++) begin
            drive(1, 1, 0, 1,0, 2, 1,1,0,0);          // lw $2
            step();
            drive(1, 2, 2, 1,1, 8, 1,0,0,0);          // add $8,$2,$2
            @(negedge clk);
            chk($sformatf("sat%0d stall", k), {7'd0, stall}, 8'd1);
            step();
            step();
            chk($sformatf("sat%0d cnt", k), {4'd0, stall_cnt}, (k > 15) ? 8'd15 : 8'(k));
        end

        drive(0, 0, 0, 0,0, 0, 0,0,0,0);
        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Forwarding and load-use hazard controller for the 5-stage MIPS pipeline. It sits between decode and the EX-stage operand muxes and generates the 2-bit selects that drive the two 4:1 ALU operand multiplexers. It also raises the load-use stall. It keeps its own shadow pipeline of destination tags (EX, MEM, WB slots), so the datapath registers do not need to export hazard information.

## Interface
Parameters:
- REG_W, 5: register-index width.
- CNT_W, 16: stall-counter width.

Ports:
- clk  in  1  pipeline clock. Reset is asynchronous and active-low; one clock.
- reset  in  1  asynchronous, active-low reset.
- hold  in  1  global freeze (memory wait). All state holds while high.
- flush  in  1  squash the instruction currently in ID (branch taken).
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_W  source register indices.
- id_uses_rs, id_uses_rt  in  1  operand is actually read.
- id_dest  in  REG_W  destination index.
- id_regwrite  in  1  instruction writes the register file.
- id_memread  in  1  instruction is a load.
- fwdA_sel, fwdB_sel  out  2  registered operand-mux selects for the instruction in EX.
- stall  out  1  combinational. Hold PC/IF/ID and insert a bubble.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- Select encoding, shared with the operand mux:
  - 00: register file.
  - 01: EX/MEM ALU result.
  - 10: MEM/WB result.
  - 11: retired-last-cycle value (only when WB bypass is enabled).
- Shadow tag per slot: {valid, dest, regwrite, memread}. Slots are EX, MEM and WB.
- Advance (rising clk, hold=0):
  - WB←MEM, MEM←EX.
  - EX←ID tag if id_valid & ~stall & ~flush; otherwise EX gets a bubble (valid=0).
- Select computation happens at the same edge for the entering ID instruction, against the pre-edge slots. For operand A, using rs:
  - EX slot hit → 01.
  - else MEM slot hit → 10.
  - else WB slot hit → 11 (macro only).
  - else 00.
- Operand B is computed identically with rt.
- Hit condition: slot.valid & slot.regwrite & slot.dest==src & src!=0 & uses_src. Nearest slot wins.
- Bubble entering EX drives both selects to 00.
- stall = id_valid & ~flush & EX.valid & EX.memread & EX.dest!=0 & ((uses_rs & rs==EX.dest) | (uses_rt & rt==EX.dest)).
- stall_cnt increments on each edge with stall=1 and hold=0. It saturates at all-ones; no wrap.

## Timing
- Reset (async, reset=0):
  - all slot valid=0.
  - fwdA_sel=fwdB_sel=00.
  - stall_cnt=0.
  - stall therefore reads 0.
- Reset mid-operation discards all tags immediately. The first instruction after release sees no hazards.
- Select latency: 1 cycle. Selects are valid for the whole cycle the instruction occupies EX.
- stall is the same cycle as detection. A load-use pair costs exactly 1 stall cycle. After the bubble, the load sits in MEM and the consumer gets 10.
- hold=1: slots, selects and stall_cnt are frozen. stall may still assert, but is not counted.
- flush and stall in the same cycle: flush wins, stall=0, EX gets a bubble.
- Writes to register 0 are never forwarded.

## Configuration
- FWD_WB_BYPASS_EN defined: the WB slot participates and select 11 can be produced. Use this for a read-before-write register file.
- Not defined: the WB slot is still tracked but ignored; 11 is never output. The register file must be write-first.

## Structure
- Shared package mips_pipe_pkg holds:
  - FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_WB (2-bit constants).
  - REG_ZERO.
  - the stage-tag struct typedef.
- One sub-module, fwd_compare: combinational priority compare of one source index against the three slots, returning a 2-bit select. Instantiate it twice (A/rs, B/rt).

## Test plan
- Back-to-back ALU dependency (add $3,… ; sub $4,$3,$5) → next cycle fwdA_sel=01, fwdB_sel=00, stall=0.
- Dependency at distance 2 (add $3 ; nop ; or $6,$7,$3) → fwdB_sel=10. At distance 3, with the macro: 11; without the macro: 00.
- Load-use (lw $2 ; add $8,$2,$2):
  - stall=1 for exactly 1 cycle.
  - bubble gives selects 00.
  - then fwdA_sel=fwdB_sel=10.
  - stall_cnt=1.
- Destination $0 written then read → selects 00, no stall. Double hit (EX and MEM both write $3) → 01 (nearest).
- flush asserted together with a load-use hazard → stall=0 and EX bubble. hold=1 for 3 cycles mid-sequence → outputs and stall_cnt unchanged, then resume correctly.
- Assert reset during a pending stall → stall drops immediately and selects go to 00. Force stall_cnt to all-ones with CNT_W=4 → the counter stays at 15.
